jtkunio_scroll_gen: RTL and testbench
=====================================

Name: jtkunio_scroll_gen

Overview:
- Parametrised tilemap scroll layer. Successor to the fixed 3bpp/16x16 Kunio scroll.
- Generic over bit depth, palette width, tile-code width, map width and horizontal wrap.
- Fetches tiles through a proper rom_cs/rom_ok handshake, with a fetch FSM running one 8-pixel group ahead of the video beam.
- Sits between the CPU bus and the video mixer. Its ROM port goes to the SDRAM arbiter.

Parameters:
- BPP, 3, bits per pixel (1..4).
- PALW, 3, palette bits taken from map attribute [15 -: PALW].
- CODEW, 11, tile-code bits taken from map attribute [CODEW-1:0] (CODEW ≤ 16-PALW).
- MAPW, 6, log2 of map columns. Map rows fixed at 16, so VRAM depth is 2^(MAPW+4) words.
- HOFFSET, 16, pipeline compensation added to h.
- HWRAP, 384, h counter period. hadv wraps modulo HWRAP.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pxl_cen  in  1  pixel clock enable
- flip  in  1  screen flip
- h  in  9  horizontal counter
- v  in  8  vertical counter
- hscr  in  MAPW+4  horizontal scroll position
- vscr  in  8  vertical scroll (only with JTKUNIO_SCR_VSCROLL_EN)
- cpu_addr  in  MAPW+5  byte address. MSB selects high byte.
- scr_cs  in  1  VRAM chip select
- cpu_wrn  in  1  write strobe, active low
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data
- rom_cs  out  1  ROM request
- rom_addr  out  CODEW+5  {code, half, row[3:0]}
- rom_data  in  32  bit rom_data[p*8+x] = plane p, pixel x
- rom_ok  in  1  data valid for the current rom_addr
- pxl  out  PALW+BPP  {pal, colour}. Colour 0 means transparent.

Behaviour:
- Reset (async) clears:
  - pxl=0, rom_cs=0, rom_addr=0.
  - Shifter, palette and FSM; FSM goes to IDLE.
  - VRAM contents are not cleared.
- Horizontal address:
  - hadv = (h+HOFFSET) mod HWRAP, XORed with all-ones when flip.
  - hsum = hadv + hscr − (flip ? 0 : 256), truncated to MAPW+4 bits, so the map wraps.
- Vertical row: vrow = v, or v+vscr mod 256 when the macro is defined.
- Map address = {vrow[7:4], hsum[MAPW+3:4]}.
- FSM runs only on pxl_cen, one fetch per 8-pixel group:
  - IDLE → ATTR when hsum[2:0]==0. Latches the map word for the NEXT group (hsum+8), one cycle of RAM latency.
  - ATTR → ROM: drive rom_addr, assert rom_cs.
  - ROM → READY on the pxl_cen where rom_ok=1. Capture BPP planes, drop rom_cs.
  - READY → IDLE at hsum[2:0]==7. Load shifter and palette with the prefetched group.
- ROM miss: if rom_ok has not arrived by hsum[2:0]==7:
  - Shifter loads zeros (transparent group).
  - FSM abandons the fetch (rom_cs low) and restarts for the next group.
  - No stall ever propagates to video timing.
- rom_addr must stay stable while rom_cs=1.
- Shifter:
  - Shifts right (pixel 0 first), or left when flip.
  - pxl is registered, one pxl_cen after shift. Total h→pxl latency is fixed at 9 pixels, absorbed by HOFFSET.
- CPU port:
  - Write when scr_cs & ~cpu_wrn. The byte lane is selected by the cpu_addr MSB.
  - cpu_din gives the selected byte with 1-clk RAM latency.
  - A simultaneous CPU write and scan read of the same word returns the old data on the scan side.

Optional Feature:
- JTKUNIO_SCR_VSCROLL_EN defined:
  - vscr port exists; vrow = v+vscr (8-bit wrap).
  - rom_addr row uses vrow[3:0].
- Undefined:
  - Port absent; vrow = v.
  - Logic identical to the fixed-row original.

Decomposition:
- Package jtkunio_scroll_pkg:
  - FSM state enum (IDLE, ATTR, ROM, READY).
  - Function for the plane-extract bit index.
  - Default HOFFSET/HWRAP constants.
- One sub-module jtkunio_scroll_shift (parametric BPP/PALW):
  - Parallel load, flip-direction shift, registered pxl.
- VRAM uses the existing jtframe_dual_ram16.

Test Plan:
- Reset asserted mid-fetch (rom_cs=1) → rom_cs=0 and pxl=0 asynchronously. First fetch restarts at next hsum[2:0]==0.
- VRAM word 0x6123 at map (0,0), hscr=256, flip=0, BPP=3, PALW=3, CODEW=11, ROM returns 0x000000FF → rom_addr code=0x123 and pxl=6'b011_001 for 8 consecutive pixels.
- rom_ok held low through a whole group → that group outputs pxl colour 0; the next group with rom_ok immediate renders normally.
- hscr=(2^(MAPW+4))−4 → the 5th pixel of the line fetches map column 0 (wrap). No X on rom_addr.
- flip=1 with the same ROM pattern 0x00000001 → colour 1 appears at the last pixel of the group instead of the first.
- CPU writes 0xAB to high byte, then reads back → cpu_din=0xAB one clk later. A scan at the same address during the write sees the previous value.

Source files
------------

// File: rtl/jtkunio_scroll_pkg.sv
// Shared types and constants for the jtkunio_scroll_gen tilemap layer.
package jtkunio_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ATTR  = 2'd1,
        ROM   = 2'd2,
        READY = 2'd3
    } scr_state_t;

    localparam int DEF_HOFFSET = 16;
    localparam int DEF_HWRAP   = 384;

    // ROM word layout: bit p*8+x carries plane p of pixel x.
    function automatic logic [4:0] plane_bit(input int p, input int x);
        return 5'(p * 8 + x);
    endfunction

endpackage

// File: rtl/jtframe_dual_ram16.sv
// 16-bit dual-port RAM: port 0 read/write with byte enables, port 1 read-only (old data on collision).
module jtframe_dual_ram16 #(
    parameter int AW = 10
) (
    input  logic          clk0,
    input  logic [15:0]   data0,
    input  logic [AW-1:0] addr0,
    input  logic [1:0]    we0,
    output logic [15:0]   q0,
    input  logic          clk1,
    input  logic [AW-1:0] addr1,
    output logic [15:0]   q1
);
    logic [15:0] r_mem [0:(2**AW)-1];

    // Port 0: byte-lane writes and registered read
    always_ff @(posedge clk0) begin
        if (we0[0]) r_mem[addr0][7:0]  <= data0[7:0];
        if (we0[1]) r_mem[addr0][15:8] <= data0[15:8];
        q0 <= r_mem[addr0];
    end

    // Port 1: registered scan read
    always_ff @(posedge clk1) begin
        q1 <= r_mem[addr1];
    end

endmodule

// File: rtl/jtkunio_scroll_shift.sv
// Pixel shifter: parallel load of one 8-pixel group, direction set by flip, registered pxl.
module jtkunio_scroll_shift #(
    parameter int BPP  = 3,
    parameter int PALW = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pxl_cen,
    input  logic                  flip,
    input  logic                  load,
    input  logic [BPP-1:0][7:0]   planes,
    input  logic [PALW-1:0]       pal,
    output logic [PALW+BPP-1:0]   pxl
);
    logic [BPP-1:0][7:0] r_sh;
    logic [PALW-1:0]     r_pal;
    logic [BPP-1:0]      w_col;

    // Current pixel colour: bit 0 normally, bit 7 when flipped
    always_comb begin
        w_col = '0;
        for (int p = 0; p < BPP; p++) begin
            w_col[p] = flip ? r_sh[p][7] : r_sh[p][0];
        end
    end

    // Shift register, palette hold and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_pal <= '0;
            pxl   <= '0;
        end else if (pxl_cen) begin
            pxl <= {r_pal, w_col};
            if (load) begin
                r_sh  <= planes;
                r_pal <= pal;
            end else begin
                for (int p = 0; p < BPP; p++) begin
                    r_sh[p] <= flip ? {r_sh[p][6:0], 1'b0} : {1'b0, r_sh[p][7:1]};
                end
            end
        end
    end

endmodule

// File: rtl/jtkunio_scroll_gen.sv
// Parametrised tilemap scroll layer with one-group-ahead ROM prefetch.
// Build option: define JTKUNIO_SCR_VSCROLL_EN to add the vscr vertical scroll input.
module jtkunio_scroll_gen
    import jtkunio_scroll_pkg::*;
#(
    parameter int BPP     = 3,
    parameter int PALW    = 3,
    parameter int CODEW   = 11,
    parameter int MAPW    = 6,
    parameter int HOFFSET = DEF_HOFFSET,
    parameter int HWRAP   = DEF_HWRAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pxl_cen,
    input  logic                  flip,
    input  logic [8:0]            h,
    input  logic [7:0]            v,
    input  logic [MAPW+3:0]       hscr,
`ifdef JTKUNIO_SCR_VSCROLL_EN
    input  logic [7:0]            vscr,
`endif
    input  logic [MAPW+4:0]       cpu_addr,
    input  logic                  scr_cs,
    input  logic                  cpu_wrn,
    input  logic [7:0]            cpu_dout,
    output logic [7:0]            cpu_din,
    output logic                  rom_cs,
    output logic [CODEW+4:0]      rom_addr,
    input  logic [31:0]           rom_data,
    input  logic                  rom_ok,
    output logic [PALW+BPP-1:0]   pxl
);
    localparam int HW = MAPW + 4;

    logic [9:0]          w_hext;
    logic [9:0]          w_hmod;
    logic [8:0]          w_hadv;
    logic [HW-1:0]       w_hsum;
    logic [HW-1:0]       w_hnext;
    logic [2:0]          w_phase;
    logic [7:0]          w_vrow;
    logic [HW-1:0]       w_scan_addr;
    logic [15:0]         w_q0;
    logic [15:0]         w_q1;
    logic [1:0]          w_we;
    logic                w_load;
    logic [BPP-1:0][7:0] w_rom_planes;
    logic [BPP-1:0][7:0] w_ld_planes;
    logic                w_unused;

    scr_state_t          r_st;
    logic [PALW-1:0]     r_pal;
    logic [BPP-1:0][7:0] r_planes;
    logic                r_cpu_hi;

    assign w_hext  = {1'b0, h} + 10'(HOFFSET);
    assign w_hmod  = (w_hext >= 10'(HWRAP)) ? (w_hext - 10'(HWRAP)) : w_hext;
    assign w_hadv  = w_hmod[8:0] ^ {9{flip}};
    assign w_hsum  = HW'(w_hadv) + hscr - (flip ? {HW{1'b0}} : HW'(256));
    // Flip walks hsum downwards, so group phase and the prefetch target mirror with it.
    assign w_phase = w_hsum[2:0] ^ {3{flip}};
    assign w_hnext = flip ? (w_hsum - HW'(8)) : (w_hsum + HW'(8));
`ifdef JTKUNIO_SCR_VSCROLL_EN
    assign w_vrow  = v + vscr;
`else
    assign w_vrow  = v;
`endif
    assign w_scan_addr = {w_vrow[7:4], w_hnext[HW-1:4]};

    assign w_we    = {2{scr_cs & ~cpu_wrn}} & {cpu_addr[HW], ~cpu_addr[HW]};
    assign cpu_din = r_cpu_hi ? w_q0[15:8] : w_q0[7:0];

    jtframe_dual_ram16 #(.AW(HW)) u_vram (
        .clk0   (clk),
        .data0  ({cpu_dout, cpu_dout}),
        .addr0  (cpu_addr[HW-1:0]),
        .we0    (w_we),
        .q0     (w_q0),
        .clk1   (clk),
        .addr1  (w_scan_addr),
        .q1     (w_q1)
    );

    // Plane extraction from the ROM word
    always_comb begin
        w_rom_planes = '0;
        for (int p = 0; p < BPP; p++) begin
            for (int x = 0; x < 8; x++) begin
                w_rom_planes[p][x] = rom_data[plane_bit(p, x)];
            end
        end
    end

    assign w_load      = pxl_cen & (w_phase == 3'd7);
    assign w_ld_planes = (r_st == READY) ? r_planes : '0;
    assign w_unused    = ^{w_q1, w_hnext[2:0], w_hmod[9], rom_data};

    // CPU read byte-lane select tracks the RAM latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_hi <= 1'b0;
        end else begin
            r_cpu_hi <= cpu_addr[HW];
        end
    end

    // Fetch FSM, one group ahead of the beam; group end always returns to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st     <= IDLE;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            r_pal    <= '0;
            r_planes <= '0;
        end else if (pxl_cen) begin
            if (w_phase == 3'd7) begin
                r_st   <= IDLE;
                rom_cs <= 1'b0;
            end else begin
                case (r_st)
                    IDLE: begin
                        if (w_phase == 3'd0) r_st <= ATTR;
                    end
                    ATTR: begin
                        r_pal    <= w_q1[15 -: PALW];
                        rom_addr <= {w_q1[CODEW-1:0], w_hnext[3], w_vrow[3:0]};
                        rom_cs   <= 1'b1;
                        r_st     <= ROM;
                    end
                    ROM: begin
                        if (rom_ok) begin
                            r_planes <= w_rom_planes;
                            rom_cs   <= 1'b0;
                            r_st     <= READY;
                        end
                    end
                    READY:   r_st <= READY;
                    default: r_st <= IDLE;
                endcase
            end
        end
    end

    jtkunio_scroll_shift #(.BPP(BPP), .PALW(PALW)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .pxl_cen (pxl_cen),
        .flip    (flip),
        .load    (w_load),
        .planes  (w_ld_planes),
        .pal     (r_pal),
        .pxl     (pxl)
    );

endmodule

// File: tb/tb_jtkunio_scroll_gen.sv
// Directed self-checking bench for jtkunio_scroll_gen (default build, vscr absent).
module tb_jtkunio_scroll_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        flip = 1'b0;
    logic [8:0]  h = 9'd0;
    logic [7:0]  v = 8'd0;
    logic [9:0]  hscr = 10'd0;
    logic [10:0] cpu_addr = 11'd0;
    logic        scr_cs = 1'b0;
    logic        cpu_wrn = 1'b1;
    logic [7:0]  cpu_dout = 8'd0;
    logic [7:0]  cpu_din;
    logic        rom_cs;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic [5:0]  pxl;

    logic        rom_en = 1'b1;
    logic [31:0] rom_pat = 32'd0;
    logic [2:0]  col_tab [8];
    int          errors = 0;
    int          checks = 0;

    assign rom_ok   = rom_cs & rom_en;
    assign rom_data = rom_pat;

    always #5 clk = ~clk;

    jtkunio_scroll_gen dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .flip     (flip),
        .h        (h),
        .v        (v),
        .hscr     (hscr),
        .cpu_addr (cpu_addr),
        .scr_cs   (scr_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .pxl      (pxl)
    );

    task automatic step(input logic [8:0] hv);
        pxl_cen = 1'b1;
        h = hv;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
        pxl_cen  = 1'b0;
        cpu_addr = a;
        cpu_dout = d;
        scr_cs   = 1'b1;
        cpu_wrn  = 1'b0;
        @(posedge clk);
        #1;
        scr_cs   = 1'b0;
        cpu_wrn  = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (pxl !== 6'd0) begin errors++; $display("FAIL reset_pxl got=%b want=%b", pxl, 6'd0); end
        checks++;
        if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs got=%b want=0", rom_cs); end
        checks++;
        if (rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_rom_addr got=%h want=0000", rom_addr); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_render();
        flip = 1'b0; v = 8'd5; hscr = 10'd192; rom_en = 1'b1; rom_pat = 32'h000000FF;
        for (int hh = 39; hh <= 41; hh++) step(9'(hh));
        checks++;
        if (rom_addr !== 16'h2465 || rom_cs !== 1'b1) begin
            errors++; $display("FAIL render_addr0 got=%h cs=%b want=2465 cs=1", rom_addr, rom_cs);
        end
        for (int hh = 42; hh <= 47; hh++) step(9'(hh));
        rom_pat = 32'hFF040281;
        for (int hh = 48; hh <= 55; hh++) begin
            step(9'(hh));
            checks++;
            if (pxl !== 6'b011001) begin errors++; $display("FAIL render_px h=%0d got=%b want=011001", hh, pxl); end
            if (hh == 49) begin
                checks++;
                if (rom_addr !== 16'h2475) begin errors++; $display("FAIL render_addr1 got=%h want=2475", rom_addr); end
            end
        end
        for (int hh = 56; hh <= 63; hh++) begin
            step(9'(hh));
            checks++;
            if (pxl !== {3'b011, col_tab[hh-56]}) begin
                errors++; $display("FAIL render_order h=%0d got=%b want=%b", hh, pxl, {3'b011, col_tab[hh-56]});
            end
        end
    endtask

    task automatic test_rom_miss();
        flip = 1'b0; v = 8'd0; hscr = 10'd192; rom_en = 1'b0; rom_pat = 32'h000000FF;
        for (int hh = 39; hh <= 46; hh++) step(9'(hh));
        checks++;
        if (rom_cs !== 1'b1) begin errors++; $display("FAIL miss_cs_held got=%b want=1", rom_cs); end
        step(9'd47);
        checks++;
        if (rom_cs !== 1'b0) begin errors++; $display("FAIL miss_cs_drop got=%b want=0", rom_cs); end
        rom_en = 1'b1;
        for (int hh = 48; hh <= 55; hh++) begin
            step(9'(hh));
            checks++;
            if (pxl[2:0] !== 3'b000) begin errors++; $display("FAIL miss_px h=%0d got=%b want=000", hh, pxl[2:0]); end
        end
        for (int hh = 56; hh <= 63; hh++) begin
            step(9'(hh));
            checks++;
            if (pxl !== 6'b011001) begin errors++; $display("FAIL miss_recover h=%0d got=%b want=011001", hh, pxl); end
        end
    endtask

    task automatic test_wrap();
        flip = 1'b0; v = 8'd0; hscr = 10'h3FC; rom_en = 1'b1; rom_pat = 32'h000000FF;
        for (int hh = 227; hh <= 229; hh++) step(9'(hh));
        checks++;
        if (rom_addr !== 16'h0EF0) begin errors++; $display("FAIL wrap_addr63 got=%h want=0EF0", rom_addr); end
        for (int hh = 230; hh <= 251; hh++) begin
            step(9'(hh));
            if (hh == 237) begin
                checks++;
                if (rom_addr !== 16'h2460 || (^rom_addr) === 1'bx) begin
                    errors++; $display("FAIL wrap_addr0 got=%h want=2460", rom_addr);
                end
            end
            if (hh >= 236 && hh <= 243) begin
                checks++;
                if (pxl !== 6'b001001) begin errors++; $display("FAIL wrap_col63 h=%0d got=%b want=001001", hh, pxl); end
            end
            if (hh >= 244) begin
                checks++;
                if (pxl !== 6'b011001) begin errors++; $display("FAIL wrap_col0 h=%0d got=%b want=011001", hh, pxl); end
            end
        end
    endtask

    task automatic test_flip();
        flip = 1'b1; v = 8'd0; hscr = 10'd729; rom_en = 1'b1; rom_pat = 32'h00000001;
        for (int hh = 184; hh <= 186; hh++) step(9'(hh));
        checks++;
        if (rom_addr !== 16'h2460) begin errors++; $display("FAIL flip_addr got=%h want=2460", rom_addr); end
        for (int hh = 187; hh <= 192; hh++) step(9'(hh));
        for (int hh = 193; hh <= 200; hh++) begin
            step(9'(hh));
            checks++;
            if (pxl !== ((hh == 200) ? 6'b011001 : 6'b011000)) begin
                errors++; $display("FAIL flip_px h=%0d got=%b want=%b", hh, pxl, (hh == 200) ? 6'b011001 : 6'b011000);
            end
        end
        flip = 1'b0;
    endtask

    task automatic test_cpu_port();
        flip = 1'b0; v = 8'd0; hscr = 10'd192; rom_en = 1'b1; rom_pat = 32'h000000FF;
        step(9'd39);
        cpu_addr = 11'h400; cpu_dout = 8'hAB; scr_cs = 1'b1; cpu_wrn = 1'b0;
        step(9'd40);
        scr_cs = 1'b0; cpu_wrn = 1'b1;
        step(9'd41);
        checks++;
        if (rom_addr !== 16'h2460) begin errors++; $display("FAIL cpu_scan_old got=%h want=2460", rom_addr); end
        checks++;
        if (cpu_din !== 8'hAB) begin errors++; $display("FAIL cpu_rd_hi got=%h want=AB", cpu_din); end
        cpu_addr = 11'h000;
        step(9'd42);
        checks++;
        if (cpu_din !== 8'h23) begin errors++; $display("FAIL cpu_rd_lo got=%h want=23", cpu_din); end
        for (int hh = 43; hh <= 49; hh++) step(9'(hh));
        checks++;
        if (rom_addr !== 16'h6470) begin errors++; $display("FAIL cpu_scan_new got=%h want=6470", rom_addr); end
        for (int hh = 50; hh <= 56; hh++) step(9'(hh));
        checks++;
        if (pxl !== 6'b101001) begin errors++; $display("FAIL cpu_new_pal got=%b want=101001", pxl); end
    endtask

    task automatic test_reset_mid_fetch();
        flip = 1'b0; v = 8'd0; hscr = 10'd192; rom_en = 1'b1; rom_pat = 32'h000000FF;
        for (int hh = 39; hh <= 47; hh++) step(9'(hh));
        rom_en = 1'b0;
        for (int hh = 48; hh <= 50; hh++) step(9'(hh));
        checks++;
        if (rom_cs !== 1'b1 || pxl !== 6'b101001) begin
            errors++; $display("FAIL rstmid_pre cs=%b pxl=%b want cs=1 pxl=101001", rom_cs, pxl);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rom_cs !== 1'b0 || pxl !== 6'd0 || rom_addr !== 16'h0000) begin
            errors++; $display("FAIL rstmid_async cs=%b pxl=%b addr=%h want 0", rom_cs, pxl, rom_addr);
        end
        #2 rst = 1'b0;
        rom_en = 1'b1;
        for (int hh = 51; hh <= 56; hh++) begin
            step(9'(hh));
            checks++;
            if (rom_cs !== 1'b0) begin errors++; $display("FAIL rstmid_idle h=%0d got=%b want=0", hh, rom_cs); end
        end
        step(9'd57);
        checks++;
        if (rom_cs !== 1'b1 || rom_addr !== 16'h0AA0) begin
            errors++; $display("FAIL rstmid_restart cs=%b addr=%h want cs=1 addr=0AA0", rom_cs, rom_addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        col_tab = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
        test_reset();
        cpu_wr(11'h400, 8'h61);
        cpu_wr(11'h000, 8'h23);
        cpu_wr(11'h401, 8'h40);
        cpu_wr(11'h001, 8'h55);
        cpu_wr(11'h43F, 8'h20);
        cpu_wr(11'h03F, 8'h77);
        test_render();
        test_rom_miss();
        test_wrap();
        test_flip();
        test_cpu_port();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
